// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : default 640x480@60 timing constants and FSM state types          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vga_pkg;

  localparam int CONT_W = 10;

  localparam int DEF_H_ATIVO  = 640;
  localparam int DEF_H_FRENTE = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_TRAS   = 48;

  localparam int DEF_V_ATIVO  = 480;
  localparam int DEF_V_FRENTE = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_TRAS   = 33;

  localparam int H_TOTAL = DEF_H_ATIVO + DEF_H_FRENTE + DEF_H_SYNC + DEF_H_TRAS;
  localparam int V_TOTAL = DEF_V_ATIVO + DEF_V_FRENTE + DEF_V_SYNC + DEF_V_TRAS;

  typedef enum logic [1:0] {
    H_ATIVA = 2'd0,
    H_FP    = 2'd1,
    H_SINC  = 2'd2,
    H_BP    = 2'd3
  } h_estado_t;

  typedef enum logic [1:0] {
    V_ATIVA = 2'd0,
    V_FP    = 2'd1,
    V_SINC  = 2'd2,
    V_BP    = 2'd3
  } v_estado_t;

endpackage
`default_nettype wire

// File: rtl/vga_contador_fase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_contador_fase : wrapping counter flagging entry into each timing phase |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_contador_fase import vga_pkg::*; #(
  parameter int TOTAL  = 800,
  parameter int B_FP   = 640,
  parameter int B_SYNC = 656,
  parameter int B_BP   = 752
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [CONT_W-1:0] contagem,
  output logic [CONT_W-1:0] prox,
  output logic              entra_ativa,
  output logic              entra_fp,
  output logic              entra_sync,
  output logic              entra_bp
);

  logic fim;

  assign fim = (contagem == CONT_W'(TOTAL - 1));

  // prox is the value the counter will hold after this cycle
  always_comb begin
    prox = contagem;
    if (en) prox = fim ? '0 : contagem + CONT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) contagem <= '0;
    else        contagem <= prox;
  end

  assign entra_ativa = en & fim;
  assign entra_fp    = en & (prox == CONT_W'(B_FP));
  assign entra_sync  = en & (prox == CONT_W'(B_SYNC));
  assign entra_bp    = en & (prox == CONT_W'(B_BP));

endmodule
`default_nettype wire

// File: rtl/vga_sincronismo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_sincronismo : VGA hsync/vsync/active-area timing generator             |
// | Optional VGA_DIV_CLK2_EN: pixel rate is clk/2.   Rev 1.0                   |
// +----------------------------------------------------------------------------+
module vga_sincronismo import vga_pkg::*; #(
  parameter int H_ATIVO  = DEF_H_ATIVO,
  parameter int H_FRENTE = DEF_H_FRENTE,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_TRAS   = DEF_H_TRAS,
  parameter int V_ATIVO  = DEF_V_ATIVO,
  parameter int V_FRENTE = DEF_V_FRENTE,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_TRAS   = DEF_V_TRAS
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              hsync,
  output logic              vsync,
  output logic              areaAtiva,
  output logic [CONT_W-1:0] coluna,
  output logic [CONT_W-1:0] linha,
  output logic              pixel_en,
  output logic              inicioQuadro
);

  localparam int H_TOT = H_ATIVO + H_FRENTE + H_SYNC + H_TRAS;
  localparam int V_TOT = V_ATIVO + V_FRENTE + V_SYNC + V_TRAS;

  logic              tick;
  logic              rodando;
  logic              passo;
  logic [CONT_W-1:0] h_prox, v_prox;
  logic              h_ea, h_efp, h_es, h_ebp;
  logic              v_ea, v_efp, v_es, v_ebp;
  h_estado_t         h_est, h_est_prox;
  v_estado_t         v_est, v_est_prox;
  logic              hsync_prox, vsync_prox, area_prox, inicio_prox;

`ifdef VGA_DIV_CLK2_EN
  logic div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= 1'b0;
    else        div_q <= ~div_q;
  end

  assign tick = div_q;
`else
  assign tick = 1'b1;
`endif

  // The first pixel after reset presents 0/0 without advancing the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rodando <= 1'b0;
    else if (tick) rodando <= 1'b1;
  end

  assign passo = tick & rodando;

  vga_contador_fase #(
    .TOTAL (H_TOT),
    .B_FP  (H_ATIVO),
    .B_SYNC(H_ATIVO + H_FRENTE),
    .B_BP  (H_ATIVO + H_FRENTE + H_SYNC)
  ) u_cont_h (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (passo),
    .contagem   (coluna),
    .prox       (h_prox),
    .entra_ativa(h_ea),
    .entra_fp   (h_efp),
    .entra_sync (h_es),
    .entra_bp   (h_ebp)
  );

  vga_contador_fase #(
    .TOTAL (V_TOT),
    .B_FP  (V_ATIVO),
    .B_SYNC(V_ATIVO + V_FRENTE),
    .B_BP  (V_ATIVO + V_FRENTE + V_SYNC)
  ) u_cont_v (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_ea),
    .contagem   (linha),
    .prox       (v_prox),
    .entra_ativa(v_ea),
    .entra_fp   (v_efp),
    .entra_sync (v_es),
    .entra_bp   (v_ebp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_est <= H_ATIVA;
      v_est <= V_ATIVA;
    end else begin
      h_est <= h_est_prox;
      v_est <= v_est_prox;
    end
  end

  always_comb begin
    h_est_prox = h_est;
    case (h_est)
      H_ATIVA: if (h_efp) h_est_prox = H_FP;
      H_FP:    if (h_es)  h_est_prox = H_SINC;
      H_SINC:  if (h_ebp) h_est_prox = H_BP;
      H_BP:    if (h_ea)  h_est_prox = H_ATIVA;
      default:            h_est_prox = H_ATIVA;
    endcase

    v_est_prox = v_est;
    case (v_est)
      V_ATIVA: if (v_efp) v_est_prox = V_FP;
      V_FP:    if (v_es)  v_est_prox = V_SINC;
      V_SINC:  if (v_ebp) v_est_prox = V_BP;
      V_BP:    if (v_ea)  v_est_prox = V_ATIVA;
      default:            v_est_prox = V_ATIVA;
    endcase
  end

  // Decoded from the next state so the registered flags line up with coluna/linha
  always_comb begin
    hsync_prox  = (h_est_prox != H_SINC);
    vsync_prox  = (v_est_prox != V_SINC);
    area_prox   = (h_est_prox == H_ATIVA) && (v_est_prox == V_ATIVA);
    inicio_prox = (h_prox == '0) && (v_prox == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      areaAtiva    <= 1'b0;
      inicioQuadro <= 1'b0;
      pixel_en     <= 1'b0;
    end else begin
      pixel_en <= tick;
      if (tick) begin
        hsync        <= hsync_prox;
        vsync        <= vsync_prox;
        areaAtiva    <= area_prox;
        inicioQuadro <= inicio_prox;
      end
    end
  end

endmodule
`default_nettype wire
